// File: rtl/delay_pkg.sv
// rtl/delay_pkg.sv - shared width constant and data type for the delay line
package delay_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [DEFAULT_WIDTH-1:0] data_t;

endpackage : delay_pkg

// File: rtl/delay_stage.sv
// rtl/delay_stage.sv - single WIDTH-bit register with synchronous reset
module delay_stage
  import delay_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // capture d every edge; reset clears the stage so no stale sample survives
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule : delay_stage

// File: rtl/delay_ex.sv
// rtl/delay_ex.sv - two-tap synchronous delay line
module delay_ex
  import delay_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int TAP1  = 1,
  parameter int TAP2  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2
);

  // reject tap/width combinations the chain cannot represent
  if (TAP1 < 1 || TAP2 < TAP1 || WIDTH < 1) begin : g_bad_params
    $error("delay_ex: illegal parameters WIDTH=%0d TAP1=%0d TAP2=%0d", WIDTH, TAP1, TAP2);
  end

  logic [WIDTH-1:0] stage [TAP2];

  // shift chain: stage 0 takes the input, each later stage takes its predecessor
  for (genvar k = 0; k < TAP2; k++) begin : g_chain
    if (k == 0) begin : g_head
      delay_stage #(.WIDTH(WIDTH)) u_stage (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (stage[0])
      );
    end else begin : g_body
      delay_stage #(.WIDTH(WIDTH)) u_stage (
        .clk (clk),
        .rst (rst),
        .d   (stage[k-1]),
        .q   (stage[k])
      );
    end
  end

  // both taps are straight register outputs, no path from in
  assign out1 = stage[TAP1-1];
  assign out2 = stage[TAP2-1];

endmodule : delay_ex

// File: tb/tb_delay_ex.sv
// tb/tb_delay_ex.sv - self-checking bench for delay_ex (default and 2/4 tap variant)
module tb_delay_ex;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic [3:0] a_out1, a_out2;
  logic [3:0] b_out1, b_out2;

  int checks   = 0;
  int failures = 0;

  // sampled input history since the last reset, newest at the back
  logic [3:0] hist [$];
  bit         seen_reset = 1'b0;

  delay_ex #(.WIDTH(4), .TAP1(1), .TAP2(2)) u_dut_a (
    .clk  (clk),
    .rst  (rst),
    .in   (din),
    .out1 (a_out1),
    .out2 (a_out2)
  );

  delay_ex #(.WIDTH(4), .TAP1(2), .TAP2(4)) u_dut_b (
    .clk  (clk),
    .rst  (rst),
    .in   (din),
    .out1 (b_out1),
    .out2 (b_out2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // value sampled d edges ago, or 0 if fewer than d samples since reset
  function automatic logic [3:0] delayed(input int d);
    if (hist.size() >= d) return hist[hist.size() - d];
    return 4'h0;
  endfunction

  // reference model: reset forgets all history, otherwise every edge records in
  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      seen_reset = 1'b1;
    end else begin
      hist.push_back(din);
      if (hist.size() > 16) void'(hist.pop_front());
    end
  end

  // compare every cycle once the outputs are defined
  always @(negedge clk) begin
    if (seen_reset) begin
      chk("model_a_out1", a_out1, delayed(1));
      chk("model_a_out2", a_out2, delayed(2));
      chk("model_b_out1", b_out1, delayed(2));
      chk("model_b_out2", b_out2, delayed(4));
    end
  end

  int hits1, hits2, pos1, pos2;

  initial begin
    rst = 1'b1;
    din = 4'h7;

    // reset held two edges with in=7
    repeat (2) begin
      @(negedge clk);
      chk("rst_out1", a_out1, 4'h0);
      chk("rst_out2", a_out2, 4'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rel_out1", a_out1, 4'h7);
    chk("rel_out2", a_out2, 4'h0);
    @(negedge clk);
    chk("rel_out2_late", a_out2, 4'h7);

    // basic latency
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    din = 4'h5;
    @(negedge clk);
    chk("lat1_out1", a_out1, 4'h5);
    chk("lat1_out2", a_out2, 4'h0);
    din = 4'h9;
    @(negedge clk);
    chk("lat2_out1", a_out1, 4'h9);
    chk("lat2_out2", a_out2, 4'h5);
    @(negedge clk);
    chk("lat3_out1", a_out1, 4'h9);
    chk("lat3_out2", a_out2, 4'h9);

    // streaming ramp with wrap 15 -> 0
    for (int i = 0; i < 18; i++) begin
      din = 4'(i);
      @(negedge clk);
      if (i == 16) begin
        chk("wrap_out1", a_out1, 4'h0);
        chk("wrap_out2", a_out2, 4'hf);
      end
    end

    // mid-stream reset discards 3..6
    din = 4'h3; @(negedge clk);
    din = 4'h4; @(negedge clk);
    din = 4'h5; @(negedge clk);
    din = 4'h6; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out1", a_out1, 4'h0);
    chk("mid_rst_out2", a_out2, 4'h0);
    rst = 1'b0;
    din = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_a1", a_out1, 4'h0);
      chk("post_rst_a2", a_out2, 4'h0);
      chk("post_rst_b1", b_out1, 4'h0);
      chk("post_rst_b2", b_out2, 4'h0);
    end

    // glitch between edges: only the value at the rising edge matters
    din = 4'h2;
    #1 din = 4'ha;
    #1 din = 4'h2;
    @(negedge clk);
    chk("glitch_out1", a_out1, 4'h2);
    #1 din = 4'ha;
    #1 din = 4'h2;
    @(negedge clk);
    chk("glitch_out2", a_out2, 4'h2);

    // 2/4-tap variant: single-cycle pulse of C
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    din = 4'hc;
    hits1 = 0; hits2 = 0; pos1 = -1; pos2 = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      din = 4'h0;
      if (b_out1 == 4'hc) begin hits1++; pos1 = i; end
      if (b_out2 == 4'hc) begin hits2++; pos2 = i; end
    end
    chk("pulse_b1_count", 4'(hits1), 4'h1);
    chk("pulse_b1_edge",  4'(pos1),  4'h2);
    chk("pulse_b2_count", 4'(hits2), 4'h1);
    chk("pulse_b2_edge",  4'(pos2),  4'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_delay_ex
